// File: rtl/multdiv_sequencer.sv
// Sequencer between the execute stage and the iterative mult/div unit:
// latches a request, strobes the unit once, stalls the pipeline until a
// result or timeout, presents the result for one cycle, and drains any
// operation orphaned by a flush so its late ready is never credited.
module multdiv_sequencer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MAX_CYCLES = 40,
  parameter int unsigned CNT_W      = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_mult,
  input  logic             req_div,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [4:0]       req_rd,
  input  logic             flush,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  output logic [WIDTH-1:0] md_a,
  output logic [WIDTH-1:0] md_b,
  input  logic             md_ready,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_exception,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             result_valid,
  output logic [4:0]       busy_rd,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             op_div;
  logic [4:0]       rd_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] drain_cnt;
  logic             req;
  logic             accept;
  logic             take_ready;
  logic             take_timeout;

  assign req = req_mult | req_div;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and datapath capture enables
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    take_ready   = 1'b0;
    take_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (req && !flush) begin
          accept    = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (flush) begin
          state_nxt = S_DRAIN;
        end else if (md_ready) begin
          take_ready = 1'b1;
          state_nxt  = S_DONE;
        end else if (cnt == CNT_LAST) begin
          take_timeout = 1'b1;
          state_nxt    = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_DRAIN: begin
        if (md_ready || drain_cnt == CNT_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand/tag latch, wait counter and result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      md_a      <= '0;
      md_b      <= '0;
      op_div    <= 1'b0;
      rd_q      <= 5'd0;
      cnt       <= '0;
      result    <= '0;
      exception <= 1'b0;
    end else begin
      if (accept) begin
        md_a   <= req_a;
        md_b   <= req_b;
        op_div <= req_div;
        rd_q   <= req_rd;
        cnt    <= '0;
      end
      if (state == S_WAIT && cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      if (take_ready) begin
        result    <= md_result;
        exception <= md_exception;
      end else if (take_timeout) begin
        result    <= '0;
        exception <= 1'b1;
      end
    end
  end

  // Drain counter, restarted on every entry to DRAIN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drain_cnt <= '0;
    end else if (state_nxt == S_DRAIN && state != S_DRAIN) begin
      drain_cnt <= '0;
    end else if (state == S_DRAIN && drain_cnt != CNT_MAX) begin
      drain_cnt <= drain_cnt + CNT_W'(1);
    end
  end

  // Outputs decoded from the state register
  assign ctrl_MULT    = (state == S_ISSUE) & ~op_div;
  assign ctrl_DIV     = (state == S_ISSUE) & op_div;
  assign result_valid = (state == S_DONE);
  assign busy_rd      = (state == S_ISSUE || state == S_WAIT || state == S_DONE) ? rd_q : 5'd0;
  assign cycles       = cnt;
  assign stall        = req & (state != S_DONE) & ~((state == S_IDLE) & flush);

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Controller between the execute stage and the iterative multdiv unit.
- Accepts a mult/div request from the D/X latch and latches the operands. Issues a single-cycle start strobe and holds the pipeline stall until the unit reports ready or a timeout fires.
- Presents the registered result and exception to the X/M latch for exactly one cycle.
- Handles pipeline flush by aborting and draining the in-flight operation so a stale ready can never be credited to a later instruction.

Parameters:
- WIDTH, 32, operand/result width.
- MAX_CYCLES, 40, WAIT-state cycles before forced timeout completion.
- CNT_W, 6, cycle counter width; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
- clock  in  1  master clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_mult  in  1  execute stage holds a mult.
- req_div  in  1  execute stage holds a div; never high together with req_mult.
- req_a  in  WIDTH  operand A from the D/X latch.
- req_b  in  WIDTH  operand B from the D/X latch.
- req_rd  in  5  destination register of the request.
- flush  in  1  branch/jump flush of the execute stage this cycle.
- ctrl_MULT  out  1  one-cycle mult start strobe to the unit.
- ctrl_DIV  out  1  one-cycle div start strobe to the unit.
- md_a  out  WIDTH  latched operand A to the unit.
- md_b  out  WIDTH  latched operand B to the unit.
- md_ready  in  1  unit result-ready pulse.
- md_result  in  WIDTH  unit result; valid when md_ready is high.
- md_exception  in  1  unit exception; valid when md_ready is high.
- stall  out  1  combinational; freeze PC and all pipeline latches.
- result  out  WIDTH  registered result.
- exception  out  1  registered exception, including timeout.
- result_valid  out  1  high in DONE only.
- busy_rd  out  5  req_rd of the in-flight op; 0 when IDLE/DRAIN (for hazard detection).
- cycles  out  CNT_W  cycles spent in WAIT for the current/last op.

Behaviour:
- Reset (asynchronous): state=IDLE; every registered output, md_a/md_b, the count and the stored op/tag are 0. Reset asserted mid-operation returns to IDLE immediately; no strobe, result or valid is produced afterwards.
- req = req_mult | req_div.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE:
  - If req & ~flush: latch req_a/req_b into md_a/md_b, latch op type and req_rd, clear cycles, go to ISSUE.
  - If req & flush: stay in IDLE.
- ISSUE:
  - Exactly one of ctrl_MULT/ctrl_DIV is high for this single cycle, matching the latched op.
  - md_ready is ignored in this state.
  - Next state is WAIT, or DRAIN if flush is high.
- WAIT:
  - cycles increments each cycle, saturating at MAX_CYCLES.
  - If md_ready & ~flush: register result<=md_result and exception<=md_exception, go to DONE.
  - If flush: go to DRAIN; this takes priority over md_ready in the same cycle, and that ready is discarded.
  - If cycles==MAX_CYCLES-1 without ready: result<=0, exception<=1, go to DONE.
- DONE:
  - result_valid=1 for one cycle; stall low so the pipeline advances. The request visible this cycle is the completing op and is not re-accepted.
  - Next state is IDLE.
  - result and exception hold their values until the next DONE.
- DRAIN:
  - Wait for md_ready or MAX_CYCLES elapsed (counter restarted on entry), then go to IDLE.
  - No strobes are issued and result/exception are not updated.
- stall = req & (state != DONE) & ~(state==IDLE & flush). Stall stays high through the DRAIN state while a new request waits.
- busy_rd = latched rd in ISSUE/WAIT/DONE, else 0.
- Strobes are never asserted outside ISSUE; two consecutive ops are separated by at least one IDLE cycle (minimum 4 cycles per op).

Test Plan:
- Reset during WAIT (cycles=7) -> next edge: state IDLE, stall=0 if req is low, result=0, result_valid=0; a later md_ready is ignored.
- req_mult, req_a=6, req_b=7, unit ready 17 cycles after strobe with md_result=42 -> ctrl_MULT high exactly 1 cycle; stall high until DONE; result=42, exception=0, result_valid 1 cycle, cycles=17.
- req_div, req_a=10, req_b=0, md_ready with md_exception=1, md_result=0 -> result=0, exception=1, result_valid=1; back-to-back req_mult next cycle is accepted one cycle after DONE.
- req_mult issued, flush asserted in WAIT at cycles=3, new req_div appears, stale md_ready arrives 10 cycles later -> DRAIN holds stall, no ctrl_DIV until after the stale ready, stale result never reaches result; the div then completes normally.
- MAX_CYCLES=40 and md_ready never arrives -> DONE after 40 WAIT cycles with result=0, exception=1, cycles=40.
- md_ready and flush in the same WAIT cycle -> DRAIN taken, result_valid stays 0, result unchanged.
